// File: rtl/mac_acc_pkg.sv
// rtl/mac_acc_pkg.sv - shared types and constants for the MAC accumulation sequencer
package mac_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAT  = 2'd2,
        OUT  = 2'd3
    } mac_state_e;

    localparam int LAT_W = 4;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - up counter that wraps to zero after reaching a runtime limit
module wrap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         at_limit_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_limit_o = (cnt_q == limit_i);
    assign cnt_o      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_limit_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_acc_ctrl.sv
// rtl/mac_acc_ctrl.sv - handshaked window sequencer for the MAC/accumulator pair
module mac_acc_ctrl
    import mac_acc_pkg::*;
#(
    parameter int WIDTH_CNT = 5,
    parameter int WIDTH_JOB = 8,
    parameter int MAC_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [WIDTH_CNT-1:0] cfg_len_i,
    input  logic [WIDTH_JOB-1:0] cfg_num_i,
    input  logic                 abort_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 mac_en_o,
    output logic                 acc_clear_o,
    output logic                 acc_last_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    mac_state_e           state_q, state_d;
    logic [WIDTH_CNT-1:0] len_q, len_d;
    logic [WIDTH_JOB-1:0] num_q, num_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic                 done_q, done_d;

    logic [WIDTH_CNT-1:0] beat_cnt;
    logic [WIDTH_JOB-1:0] win_cnt;
    logic                 beat_last, win_last;
    logic                 abort_hit, cfg_accept, out_hs;

    assign abort_hit  = abort_i && (state_q != IDLE);
    assign cfg_accept = cfg_ready_o && cfg_valid_i;
    assign out_hs     = out_valid_o && out_ready_i;

    assign mac_en_o    = in_valid_i && in_ready_o;
    assign acc_clear_o = mac_en_o && (beat_cnt == '0);
    assign acc_last_o  = mac_en_o && beat_last;
    assign done_o      = done_q;

    wrap_counter #(.W(WIDTH_CNT)) u_beat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (mac_en_o),
        .clr_i      (cfg_accept || abort_hit),
        .limit_i    (len_q),
        .cnt_o      (beat_cnt),
        .at_limit_o (beat_last)
    );

    // The window count parks at num_q on the final handshake; the next job clears it.
    wrap_counter #(.W(WIDTH_JOB)) u_win_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (out_hs && (win_cnt != num_q)),
        .clr_i      (cfg_accept || abort_hit),
        .limit_i    (num_q),
        .cnt_o      (win_cnt),
        .at_limit_o (win_last)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        num_d       = num_q;
        lat_d       = lat_q;
        done_d      = 1'b0;
        cfg_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        in_ready_o  = (state_q == RUN) && !abort_i;
        out_valid_o = (state_q == OUT) && !abort_i;

        if (abort_hit) begin
            state_d = IDLE;
            lat_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid_i) begin
                        len_d   = cfg_len_i;
                        num_d   = cfg_num_i;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // lat_q counts down to 1 so the result is presented MAC_LAT cycles after the last beat.
                    if (mac_en_o && beat_last) begin
                        lat_d   = LAT_W'(MAC_LAT - 1);
                        state_d = (MAC_LAT == 1) ? OUT : LAT;
                    end
                end
                LAT: begin
                    lat_d = lat_q - LAT_W'(1);
                    if (lat_q == LAT_W'(1)) begin
                        state_d = OUT;
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        if (win_last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            num_q   <= '0;
            lat_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            num_q   <= num_d;
            lat_q   <= lat_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_mac_acc_ctrl.sv
// tb/tb_mac_acc_ctrl.sv - directed self-checking bench for mac_acc_ctrl
module tb_mac_acc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic [4:0] cfg_len;
    logic [7:0] cfg_num;
    logic       abort;
    logic       in_valid;
    logic       out_ready;
    logic       cfg_ready_o, in_ready_o, mac_en_o, acc_clear_o, acc_last_o;
    logic       out_valid_o, busy_o, done_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_acc_ctrl #(.WIDTH_CNT(5), .WIDTH_JOB(8), .MAC_LAT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready_o),
        .cfg_len_i   (cfg_len),
        .cfg_num_i   (cfg_num),
        .abort_i     (abort),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .mac_en_o    (mac_en_o),
        .acc_clear_o (acc_clear_o),
        .acc_last_o  (acc_last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_len = '0; cfg_num = '0;
        abort = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        #1;
        chk("rst_cfg_ready", cfg_ready_o, 1); chk("rst_busy", busy_o, 0);
        chk("rst_in_ready", in_ready_o, 0);   chk("rst_mac_en", mac_en_o, 0);
        chk("rst_out_valid", out_valid_o, 0); chk("rst_done", done_o, 0);
        chk("rst_clear", acc_clear_o, 0);     chk("rst_last", acc_last_o, 0);
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        // Basic job: len=3, num=1
        cfg_valid = 1'b1; cfg_len = 5'd3; cfg_num = 8'd1;
        #1; chk("basic_cfg_ready", cfg_ready_o, 1); chk("basic_idle_in_ready", in_ready_o, 0);
        tick();
        cfg_valid = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 4; b++) begin
                #1;
                chk("basic_mac_en", mac_en_o, 1);
                chk("basic_clear", acc_clear_o, (b == 0));
                chk("basic_last", acc_last_o, (b == 3));
                chk("basic_no_done", done_o, 0);
                chk("basic_busy", busy_o, 1);
                tick();
            end
            #1; chk("basic_lat_valid", out_valid_o, 0); chk("basic_lat_mac_en", mac_en_o, 0);
            tick();
            #1; chk("basic_out_valid", out_valid_o, 1); chk("basic_out_in_ready", in_ready_o, 0);
            tick();
        end
        #1; chk("basic_done", done_o, 1); chk("basic_end_cfg_ready", cfg_ready_o, 1);
        chk("basic_end_mac_en", mac_en_o, 0);
        tick();
        in_valid = 1'b0;
        #1; chk("basic_done_pulse", done_o, 0);

        // Degenerate: len=0, num=0
        cfg_valid = 1'b1; cfg_len = 5'd0; cfg_num = 8'd0;
        tick();
        cfg_valid = 1'b0; in_valid = 1'b1;
        #1; chk("deg_clear", acc_clear_o, 1); chk("deg_last", acc_last_o, 1); chk("deg_mac_en", mac_en_o, 1);
        tick();
        in_valid = 1'b0;
        #1; chk("deg_lat_valid", out_valid_o, 0);
        tick();
        #1; chk("deg_out_valid", out_valid_o, 1);
        tick();
        #1; chk("deg_done", done_o, 1); chk("deg_cfg_ready", cfg_ready_o, 1); chk("deg_busy", busy_o, 0);
        tick();

        // Backpressure: len=4, in_valid toggling, out_ready low for 5 cycles
        cfg_valid = 1'b1; cfg_len = 5'd4; cfg_num = 8'd0; out_ready = 1'b0;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = ((i % 2) == 0);
            #1;
            chk("bp_in_ready", in_ready_o, (i < 9));
            chk("bp_mac_en", mac_en_o, ((i % 2) == 0));
            chk("bp_clear", acc_clear_o, (i == 0));
            chk("bp_last", acc_last_o, (i == 8));
            tick();
        end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_valid", out_valid_o, 1); chk("bp_hold_in_ready", in_ready_o, 0);
            chk("bp_hold_mac_en", mac_en_o, 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1; chk("bp_release_valid", out_valid_o, 1);
        tick();
        #1; chk("bp_done", done_o, 1);
        tick();

        // Abort in RUN at beat 2 of len=7
        cfg_valid = 1'b1; cfg_len = 5'd7; cfg_num = 8'd0;
        tick();
        cfg_valid = 1'b0; in_valid = 1'b1;
        tick(); tick();
        abort = 1'b1;
        #1; chk("abrun_mac_en", mac_en_o, 0); chk("abrun_in_ready", in_ready_o, 0); chk("abrun_last", acc_last_o, 0);
        tick();
        abort = 1'b0;
        #1; chk("abrun_idle", cfg_ready_o, 1); chk("abrun_busy", busy_o, 0);
        chk("abrun_done", done_o, 0); chk("abrun_mac_en_after", mac_en_o, 0);
        in_valid = 1'b0;
        tick();

        // Abort in OUT together with out_ready
        cfg_valid = 1'b1; cfg_len = 5'd0; cfg_num = 8'd0;
        tick();
        cfg_valid = 1'b0; in_valid = 1'b1;
        #1; chk("about_clear_after_abort", acc_clear_o, 1);
        tick();
        in_valid = 1'b0;
        tick();
        #1; chk("about_out_valid", out_valid_o, 1);
        abort = 1'b1; out_ready = 1'b1;
        #1; chk("about_withdrawn", out_valid_o, 0);
        tick();
        abort = 1'b0; out_ready = 1'b0;
        #1; chk("about_done", done_o, 0); chk("about_idle", cfg_ready_o, 1); chk("about_busy", busy_o, 0);
        tick();
        #1; chk("about_done_later", done_o, 0);

        // Reset mid-job in LAT
        cfg_valid = 1'b1; cfg_len = 5'd2; cfg_num = 8'd0;
        tick();
        cfg_valid = 1'b0; in_valid = 1'b1;
        tick(); tick(); tick();
        #1; chk("rstmid_in_lat", busy_o, 1); chk("rstmid_lat_in_ready", in_ready_o, 0);
        rst_n = 1'b0;
        #1; chk("rstmid_cfg_ready", cfg_ready_o, 1); chk("rstmid_busy", busy_o, 0);
        chk("rstmid_mac_en", mac_en_o, 0); chk("rstmid_out_valid", out_valid_o, 0);
        tick(); tick();
        rst_n = 1'b1; in_valid = 1'b0;
        #1; chk("rstmid_done", done_o, 0);
        cfg_valid = 1'b1; cfg_len = 5'd1; cfg_num = 8'd0;
        tick();
        cfg_valid = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1; chk("fresh_b0_clear", acc_clear_o, 1); chk("fresh_b0_last", acc_last_o, 0);
        tick();
        #1; chk("fresh_b1_clear", acc_clear_o, 0); chk("fresh_b1_last", acc_last_o, 1);
        tick();
        #1; chk("fresh_lat", out_valid_o, 0);
        tick();
        #1; chk("fresh_out", out_valid_o, 1);
        tick();
        #1; chk("fresh_done", done_o, 1);
        in_valid = 1'b0;
        tick();

        // Config changes ignored while busy
        cfg_valid = 1'b1; cfg_len = 5'd1; cfg_num = 8'd0;
        tick();
        cfg_len = 5'd5; in_valid = 1'b1; out_ready = 1'b1;
        #1; chk("busycfg_cfg_ready", cfg_ready_o, 0); chk("busycfg_b0_last", acc_last_o, 0);
        tick();
        #1; chk("busycfg_b1_last", acc_last_o, 1);
        tick();
        tick();
        #1; chk("busycfg_out", out_valid_o, 1);
        tick();
        #1; chk("busycfg_done", done_o, 1); chk("busycfg_accept", cfg_ready_o, 1);
        tick();
        cfg_valid = 1'b0;
        for (int b = 0; b < 6; b++) begin
            #1;
            chk("newcfg_mac_en", mac_en_o, 1);
            chk("newcfg_last", acc_last_o, (b == 5));
            tick();
        end
        in_valid = 1'b0;
        tick();
        #1; chk("newcfg_out", out_valid_o, 1);
        tick();
        #1; chk("newcfg_done", done_o, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
